// File: rtl/fd_m_pkg.sv
// fd_m_pkg: shared constants, ratio type and duty-threshold helper for the fd_m divider
package fd_m_pkg;
  localparam logic FD_M_DIV_RESET = 1'b1;
  localparam int FD_M_WMAX = 32;
  typedef logic [FD_M_WMAX-1:0] fd_m_ratio_t;
  function automatic fd_m_ratio_t ceil_half(input fd_m_ratio_t m);
    return (m >> 1) + fd_m_ratio_t'(m[0]);
  endfunction
endpackage

// File: rtl/fd_m_chan.sv
// fd_m_chan: one divider channel (counter, glitch-free ratio load, div/tick outputs); duty mode via FD_M_DUTY50_EN
module fd_m_chan
  import fd_m_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_ext,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic [W-1:0] m_i,
  output logic         div_o,
  output logic         tick_o,
  output logic [W-1:0] m_act_o
);
  logic [W-1:0] r_cnt, r_m_act, w_cnt_nxt;
  logic w_run, w_last, w_load, w_div_nxt, w_tick_nxt;
  // next-state: idle/sync restart, wrap at m_act-1, ratio load only at period boundaries
  always_comb begin
    w_run      = en_i && !sync_i;
    w_last     = (r_m_act > W'(1)) && (r_cnt == r_m_act - 1'b1);
    w_cnt_nxt  = (w_run && !w_last && r_m_act > W'(1)) ? r_cnt + 1'b1 : '0;
    w_tick_nxt = w_run && (w_last || r_m_act == W'(1));
    w_load     = !w_run || r_m_act == '0 || r_cnt == r_m_act - 1'b1;
`ifdef FD_M_DUTY50_EN
    w_div_nxt  = !w_run || r_m_act < W'(2) ||
                 fd_m_ratio_t'(w_cnt_nxt) < ceil_half(fd_m_ratio_t'(r_m_act));
`else
    w_div_nxt  = !(w_run && w_last);
`endif
  end
  // channel state registers with asynchronous reset to parked state
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_m_act <= '0;
      div_o   <= FD_M_DIV_RESET;
      tick_o  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      div_o  <= w_div_nxt;
      tick_o <= w_tick_nxt;
      if (w_load) r_m_act <= m_i;
    end
  end
  assign m_act_o = r_m_act;
endmodule

// File: rtl/fd_m_multi.sv
// fd_m_multi: NCH-channel programmable integer clock divider with global phase-aligning sync (FD_M_DUTY50_EN selects 50% duty)
module fd_m_multi
  import fd_m_pkg::*;
#(
  parameter int NCH = 2,
  parameter int W   = 4
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  input  logic [NCH*W-1:0] m_i,
  output logic [NCH-1:0]   div_o,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH*W-1:0] m_act_o
);
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    fd_m_chan #(.W(W)) u_chan (
      .clk_ext (clk_ext),
      .rst     (rst),
      .en_i    (en_i[k]),
      .sync_i  (sync_i),
      .m_i     (m_i[k*W +: W]),
      .div_o   (div_o[k]),
      .tick_o  (tick_o[k]),
      .m_act_o (m_act_o[k*W +: W])
    );
  end
endmodule

// File: tb/tb_fd_m_multi.sv
// tb_fd_m_multi: scoreboard bench for fd_m_multi (NCH=2, W=4); duty vectors under FD_M_DUTY50_EN
module tb_fd_m_multi;
  logic       clk_ext = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en_i = 2'b00;
  logic       sync_i = 1'b0;
  logic [7:0] m_i = 8'h00;
  logic [1:0] div_o, tick_o;
  logic [7:0] m_act_o;
  logic [11:0] q_exp[$];
  string       q_nm[$];
  int n_tests = 0;
  int n_fail = 0;
  logic dchk;

  fd_m_multi #(.NCH(2), .W(4)) dut (
    .clk_ext (clk_ext),
    .rst     (rst),
    .en_i    (en_i),
    .sync_i  (sync_i),
    .m_i     (m_i),
    .div_o   (div_o),
    .tick_o  (tick_o),
    .m_act_o (m_act_o)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    logic [11:0] msk;
    msk = {dchk, dchk, 10'h3ff};
    n_tests++;
    if ((act & msk) !== (exp & msk)) begin
      n_fail++;
      $display("FAIL %s: got div=%b tick=%b m_act=%h, expected div=%b tick=%b m_act=%h",
               nm, act[11:10], act[9:8], act[7:0], exp[11:10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic cyc(input logic [1:0] en, input logic s, input logic [3:0] m0, input logic [3:0] m1,
                     input logic [1:0] ed, input logic [1:0] et, input logic [3:0] a0,
                     input logic [3:0] a1, input string nm);
    en_i = en;
    sync_i = s;
    m_i = {m1, m0};
    q_exp.push_back({ed, et, a1, a0});
    q_nm.push_back(nm);
    @(negedge clk_ext);
  endtask

  initial begin
    string nm;
    logic [11:0] e;
    forever begin
      @(posedge clk_ext);
      #1;
      if (q_exp.size() != 0) begin
        nm = q_nm.pop_front();
        e = q_exp.pop_front();
        chk(nm, {div_o, tick_o, m_act_o}, e);
      end
    end
  end

  initial begin
`ifdef FD_M_DUTY50_EN
    dchk = 1'b0;
`else
    dchk = 1'b1;
`endif
    en_i = 2'b01;
    m_i = 8'h04;
    repeat (2) @(negedge clk_ext);
    chk("reset", {div_o, tick_o, m_act_o}, {2'b11, 2'b00, 8'h00});
    rst = 1'b0;
    cyc(2'b01, 0, 4, 0, 2'b11, 2'b00, 4, 0, "m4_first");
    repeat (3) cyc(2'b01, 0, 4, 0, 2'b11, 2'b00, 4, 0, "m4_count");
    cyc(2'b01, 0, 4, 0, 2'b10, 2'b01, 4, 0, "m4_wrap1");
    repeat (3) cyc(2'b01, 0, 4, 0, 2'b11, 2'b00, 4, 0, "m4_count2");
    cyc(2'b01, 0, 4, 0, 2'b10, 2'b01, 4, 0, "m4_wrap2");
    cyc(2'b01, 0, 4, 0, 2'b11, 2'b00, 4, 0, "m4_cnt1");
    cyc(2'b01, 0, 6, 0, 2'b11, 2'b00, 4, 0, "m6_midper_a");
    cyc(2'b01, 0, 6, 0, 2'b11, 2'b00, 4, 0, "m6_midper_b");
    cyc(2'b01, 0, 6, 0, 2'b10, 2'b01, 6, 0, "m6_switch");
    repeat (5) cyc(2'b01, 0, 6, 0, 2'b11, 2'b00, 6, 0, "m6_count");
    cyc(2'b01, 0, 6, 0, 2'b10, 2'b01, 6, 0, "m6_wrap");
    cyc(2'b11, 1, 3, 5, 2'b11, 2'b00, 3, 5, "sync_restart");
    repeat (2) cyc(2'b11, 0, 3, 5, 2'b11, 2'b00, 3, 5, "sync_count");
    cyc(2'b11, 0, 3, 5, 2'b10, 2'b01, 3, 5, "sync_tick_ch0");
    cyc(2'b11, 0, 3, 5, 2'b11, 2'b00, 3, 5, "sync_ch1_cnt4");
    cyc(2'b11, 0, 3, 5, 2'b01, 2'b10, 3, 5, "sync_tick_ch1");
    cyc(2'b00, 0, 0, 1, 2'b11, 2'b00, 0, 1, "m0_m1_idle");
    repeat (3) cyc(2'b11, 0, 0, 1, 2'b11, 2'b10, 0, 1, "m0_park_m1_tick");
    cyc(2'b00, 0, 5, 0, 2'b11, 2'b00, 5, 0, "m5_idle");
    repeat (2) cyc(2'b01, 0, 5, 0, 2'b11, 2'b00, 5, 0, "m5_count");
    rst = 1'b1;
    #1;
    chk("async_rst_mid", {div_o, tick_o, m_act_o}, {2'b11, 2'b00, 8'h00});
    @(negedge clk_ext);
    chk("rst_held", {div_o, tick_o, m_act_o}, {2'b11, 2'b00, 8'h00});
    rst = 1'b0;
    cyc(2'b01, 0, 5, 0, 2'b11, 2'b00, 5, 0, "m5_after_rst");
    repeat (4) cyc(2'b01, 0, 5, 0, 2'b11, 2'b00, 5, 0, "m5_to_last");
    cyc(2'b00, 0, 5, 0, 2'b11, 2'b00, 5, 0, "en_fall_at_last");
    repeat (3) cyc(2'b01, 0, 5, 0, 2'b11, 2'b00, 5, 0, "en_rise_count");
    cyc(2'b01, 0, 5, 0, 2'b11, 2'b00, 5, 0, "en_rise_cnt4");
    cyc(2'b01, 0, 5, 0, 2'b10, 2'b01, 5, 0, "en_rise_wrap");
`ifdef FD_M_DUTY50_EN
    dchk = 1'b1;
    cyc(2'b00, 0, 5, 2, 2'b11, 2'b00, 5, 2, "duty_idle");
    cyc(2'b11, 0, 5, 2, 2'b01, 2'b00, 5, 2, "duty_e1");
    cyc(2'b11, 0, 5, 2, 2'b11, 2'b10, 5, 2, "duty_e2");
    cyc(2'b11, 0, 5, 2, 2'b00, 2'b00, 5, 2, "duty_e3");
    cyc(2'b11, 0, 5, 2, 2'b10, 2'b10, 5, 2, "duty_e4");
    cyc(2'b11, 0, 5, 2, 2'b01, 2'b01, 5, 2, "duty_e5");
    cyc(2'b11, 0, 5, 2, 2'b11, 2'b10, 5, 2, "duty_e6");
`endif
    @(posedge clk_ext);
    #2;
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
